// File: rtl/alu_seq_if.sv
// Host-side handshake bundle for alu_seq: request, operands, result, flags and status.
interface alu_seq_if;
  logic        start;
  logic [2:0]  op;
  logic [15:0] opA;
  logic [15:0] opB;
  logic [15:0] result;
  logic        carry;
  logic        parity;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, op, opA, opB,
    input  result, carry, parity, busy, done, err
  );

  modport slave (
    input  start, op, opA, opB,
    output result, carry, parity, busy, done, err
  );
endinterface

// File: rtl/alu_seq.sv
// Sequences 16-bit ops as two passes through an external 8-bit ALU.
// Define ALU_SEQ_PARITY_EN to make op 5 a 16-bit parity (PAR16); otherwise op 5 is illegal.
module alu_seq (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus,
  output logic [3:0] alu_cmd,
  output logic [7:0] inA,
  output logic [7:0] inB,
  output logic       sc_i,
  output logic       pari_in,
  input  logic [7:0] rslt,
  input  logic       sc_o,
  input  logic       sc_en,
  input  logic       sc_clr,
  input  logic       pari,
  input  logic       pari_en,
  input  logic       pari_clr
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_SHL, OP_LSR, OP_ASR, OP_PAR, OP_RSV6, OP_RSV7
  } opcode_t;

  state_t      state, state_nx;
  opcode_t     op_in, op_q;
  logic [15:0] a_q, b_q;
  logic [7:0]  lo_q;
  logic        err_q;
  logic        op_legal;
  logic        hi_pass;
  logic [7:0]  a_lo_first, a_hi_first, b_lo_first;

  always_comb begin
    op_in = opcode_t'(bus.op);
`ifdef ALU_SEQ_PARITY_EN
    op_legal = (bus.op <= 3'd5);
`else
    op_legal = (bus.op <= 3'd4);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = op_legal ? LO : DONE;
      LO:      state_nx = HI;
      HI:      state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    hi_pass    = (state == HI);
    a_lo_first = hi_pass ? a_q[15:8] : a_q[7:0];
    a_hi_first = hi_pass ? a_q[7:0]  : a_q[15:8];
    b_lo_first = hi_pass ? b_q[15:8] : b_q[7:0];
    alu_cmd    = '0;
    inA        = '0;
    inB        = '0;
    bus.busy   = (state == LO) || (state == HI);
    bus.done   = (state == DONE);
    bus.err    = (state == DONE) && err_q;
    if (bus.busy) begin
      case (op_q)
        OP_ADD: begin inA = a_lo_first; inB = b_lo_first;  end
        OP_SUB: begin inA = a_lo_first; inB = ~b_lo_first; end
        OP_SHL: begin alu_cmd = 4'd2; inA = a_lo_first; end
        OP_LSR: begin alu_cmd = 4'd4; inA = a_hi_first; end
        // Top byte gets the sign-fill shift, bottom byte takes the carried bit.
        OP_ASR: begin alu_cmd = hi_pass ? 4'd4 : 4'd3; inA = a_hi_first; end
`ifdef ALU_SEQ_PARITY_EN
        OP_PAR: begin alu_cmd = 4'd8; inA = a_lo_first; end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    sc_i    = bus.carry;
    pari_in = bus.parity;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      lo_q       <= '0;
      op_q       <= OP_ADD;
      err_q      <= 1'b0;
      bus.result <= '0;
      bus.carry  <= 1'b0;
      bus.parity <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_q   <= bus.opA;
          b_q   <= bus.opB;
          op_q  <= op_in;
          err_q <= !op_legal;
          case (op_in)
            OP_ADD, OP_SHL, OP_LSR: bus.carry <= 1'b0;
            OP_SUB:                 bus.carry <= 1'b1;
`ifdef ALU_SEQ_PARITY_EN
            OP_PAR:                 bus.parity <= 1'b0;
`endif
            default: ;
          endcase
        end
        LO, HI: begin
          if (sc_clr)       bus.carry  <= 1'b0;
          else if (sc_en)   bus.carry  <= sc_o;
          if (pari_clr)     bus.parity <= 1'b0;
          else if (pari_en) bus.parity <= pari;
          if (state == LO) lo_q <= rslt;
          else begin
            case (op_q)
              OP_LSR, OP_ASR: bus.result <= {lo_q, rslt};
`ifdef ALU_SEQ_PARITY_EN
              OP_PAR:         bus.result <= {15'b0, pari};
`endif
              default:        bus.result <= {rslt, lo_q};
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port start, input, 1, request a 16-bit operation; sampled only in IDLE.
REQ-004 SHALL have port op, input, 3, opcode: 0 ADD16, 1 SUB16, 2 SHL16, 3 LSR16, 4 ASR16, 5 PAR16, 6-7 illegal.
REQ-005 SHALL have ports opA and opB, input, 16 each, operands; latched on accepted start.
REQ-006 SHALL have port result, output, 16, last completed result; held until the next completion.
REQ-007 SHALL have ports carry and parity, output, 1 each, current shift/carry and parity flag registers.
REQ-008 SHALL have ports busy, done and err, output, 1 each: busy is operation in progress; done is a one-cycle completion pulse; err is an illegal-opcode flag valid with done.
REQ-009 SHALL have ALU-side outputs alu_cmd (4), inA (8), inB (8), sc_i (1) and pari_in (1), driving the 8-bit ALU.
REQ-010 SHALL have ALU-side inputs rslt (8), sc_o, sc_en, sc_clr, pari, pari_en and pari_clr (1 each), returned from the ALU combinationally in the same cycle.

Function
REQ-011 SHALL implement FSM IDLE->LO->HI->DONE->IDLE; start=1 in IDLE moves to LO (or to DONE for an illegal op); start is ignored in all other states.
REQ-012 SHALL assert done only in DONE, for exactly 1 cycle, so the legal-op latency is start edge k -> done high in cycle k+3; busy SHALL be 1 in LO and HI only.
REQ-013 SHALL drive alu_cmd=0, inA=0, inB=0 in IDLE and DONE, and SHALL ignore ALU strobes in those states.
REQ-014 SHALL update flags only in LO/HI at the clock edge: sc_en -> carry<=sc_o; sc_clr -> carry<=0; pari_en -> parity<=pari; pari_clr -> parity<=0. The strobes are mutually exclusive per flag.
REQ-015 SHALL drive sc_i=carry and pari_in=parity at all times; on an accepted start the preset value SHALL load into the flag that the op specifies, before LO.
REQ-016 ADD16: preset carry=0; LO cmd 0 with (opA[7:0], opB[7:0]); HI cmd 0 with (opA[15:8], opB[15:8]); final carry = 17th bit.
REQ-017 SUB16: preset carry=1; same as ADD16 with inB = ~opB bytes; result = opA-opB mod 2^16; carry=1 means no borrow.
REQ-018 SHL16: preset carry=0; LO cmd 2 on opA[7:0]; HI cmd 2 on opA[15:8]; result = opA<<1; carry = opA[15].
REQ-019 LSR16: preset carry=0; LO cmd 4 on opA[15:8]; HI cmd 4 on opA[7:0]; result = opA>>1; carry = opA[0].
REQ-020 ASR16: LO cmd 3 on opA[15:8]; HI cmd 4 on opA[7:0]; result = arithmetic opA>>>1; carry = opA[0].
REQ-021 For shift ops, the LO-pass rslt SHALL form the byte order shown: high byte first for right shifts, low byte first for SHL16.
REQ-022 PAR16: preset parity=0; LO cmd 8 on opA[7:0]; HI cmd 8 on opA[15:8]; result = {15'b0, ^opA}; parity = ^opA.
REQ-023 Illegal op: SHALL issue no ALU passes, leave result and flags unchanged, and set err=1 for the done cycle; err SHALL be 0 on every legal completion.
REQ-024 SHALL update result only at the HI->DONE edge, using {HI byte, LO byte} in op-specific order, with the LO byte captured at the LO->HI edge.

Reset
REQ-025 rst_n=0 SHALL force IDLE, result=0, carry=0, parity=0, busy=0, done=0, err=0, and the latched operands to 0, immediately, including mid-operation; the aborted op SHALL produce no done.
REQ-026 The first start SHALL be accepted on the first rising edge with rst_n=1.

Configuration
REQ-027 Macro ALU_SEQ_PARITY_EN: when defined, op 5 SHALL be PAR16 per REQ-022; when undefined, op 5 SHALL be illegal per REQ-023, and parity SHALL still track the pari_en/pari_clr strobes.

Verification
REQ-028 Reset then ADD16 opA=16'h00FF, opB=16'h0001 -> done at k+3, result=16'h0100, carry=0, err=0.
REQ-029 SUB16 opA=16'h0100, opB=16'h0001 -> result=16'h00FF, carry=1; SUB16 opA=0, opB=1 -> result=16'hFFFF, carry=0.
REQ-030 SHL16 opA=16'h8081 -> 16'h0102, carry=1; LSR16 opA=16'h0181 -> 16'h00C0, carry=1; ASR16 opA=16'h8002 -> 16'hC001, carry=0.
REQ-031 PAR16 opA=16'h0107 with macro -> result=16'h0000, parity=0; opA=16'h0103 -> result=1; without macro -> err=1 and result unchanged.
REQ-032 op=6 -> done at k+1 with err=1; start pulsed during busy -> ignored; rst_n low during HI -> all outputs 0 asynchronously and no done.
